// File: rtl/simon_out_serializer_pkg.sv
// Shared SIMON definitions: serializer states, info-byte field positions, packet length.
package simon_out_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    localparam int unsigned INFO_MODE_MSB = 3;
    localparam int unsigned INFO_VALID    = 4;
    localparam int unsigned INFO_KEY      = 5;
    localparam int unsigned INFO_LAST     = 7;

    // Packet = info byte + count byte + four N-bit words.
    function automatic int unsigned simon_bytes(input int unsigned n);
        return 2 + n / 2;
    endfunction

endpackage

// File: rtl/simon_out_serializer_shifter.sv
// Byte shifter: parallel packet load, then shifts left one byte per accepted transfer.
module simon_byte_shifter #(
    parameter int unsigned BYTES = 10
) (
    input  logic               clk,
    input  logic               nR,
    input  logic               load_i,
    input  logic [BYTES*8-1:0] pkt_i,
    input  logic               shift_i,
    output logic [15:0]        head_o
);

    logic [BYTES*8-1:0] sr_q;
    logic [BYTES*8-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = pkt_i;
        end else if (shift_i) begin
            sr_d = {sr_q[BYTES*8-9:0], 8'h00};
        end
    end

    always_ff @(posedge clk) begin
        if (!nR) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    // Head byte is the one on the wire; the byte behind it is the count while in ACK.
    assign head_o = sr_q[BYTES*8-1 -: 16];

endmodule

// File: rtl/simon_out_serializer.sv
// Acknowledges SIMON output packets, filters/checks them and streams them out bytewise.
// state | meaning
// IDLE  | waiting for doneOUT, captures packet and pulses readOUT
// ACK   | waiting for doneOUT to fall, then checks info/count
// SEND  | presenting bytes on tx_*, info byte first
module simon_out_serializer
    import simon_out_serializer_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned MODE  = 0,
    localparam int unsigned BYTES = simon_bytes(N)
) (
    input  logic               clk,
    input  logic               nR,
    input  logic               doneOUT,
    input  logic [BYTES*8-1:0] pkt_in,
    output logic               readOUT,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               tx_last,
    output logic               busy,
    output logic               seq_err,
    output logic               mode_err,
    output logic [7:0]         drop_cnt
);

    localparam int unsigned CW = $clog2(BYTES);

    state_t        state_q;
    logic          readOUT_q;
    logic          tx_valid_q;
    logic          tx_last_q;
    logic          seq_err_q;
    logic          mode_err_q;
    logic [7:0]    drop_cnt_q;
    logic [7:0]    exp_q;
    logic [CW-1:0] rem_q;

    logic [15:0]   head;
    logic [7:0]    info;
    logic [7:0]    count;
    logic          load;
    logic          shift;

    assign info  = head[15:8];
    assign count = head[7:0];
    assign load  = (state_q == ST_IDLE) && doneOUT;
    assign shift = (state_q == ST_SEND) && tx_ready && (rem_q != '0);

    simon_byte_shifter #(.BYTES(BYTES)) u_shifter (
        .clk     (clk),
        .nR      (nR),
        .load_i  (load),
        .pkt_i   (pkt_in),
        .shift_i (shift),
        .head_o  (head)
    );

    always_ff @(posedge clk) begin
        if (!nR) begin
            state_q    <= ST_IDLE;
            readOUT_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            seq_err_q  <= 1'b0;
            mode_err_q <= 1'b0;
            drop_cnt_q <= 8'd0;
            exp_q      <= 8'd0;
            rem_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (doneOUT) begin
                        readOUT_q <= 1'b1;
                        state_q   <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    readOUT_q <= 1'b0;
                    if (!doneOUT) begin
                        if (!info[INFO_VALID]) begin
                            drop_cnt_q <= drop_cnt_q + 8'd1;
                            state_q    <= ST_IDLE;
                        end else begin
                            // Match or resync both leave expected at count+1.
                            if (count != exp_q) begin
                                seq_err_q <= 1'b1;
                            end
                            exp_q <= count + 8'd1;
                            if (info[INFO_MODE_MSB:0] != 4'(MODE)) begin
                                mode_err_q <= 1'b1;
                            end
                            rem_q      <= CW'(BYTES - 1);
                            tx_valid_q <= 1'b1;
                            tx_last_q  <= 1'b0;
                            state_q    <= ST_SEND;
                        end
                    end
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        if (rem_q == '0) begin
                            tx_valid_q <= 1'b0;
                            tx_last_q  <= 1'b0;
                            state_q    <= ST_IDLE;
                        end else begin
                            rem_q     <= rem_q - CW'(1);
                            tx_last_q <= (rem_q == CW'(1));
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign readOUT  = readOUT_q;
    assign tx_data  = head[15:8];
    assign tx_valid = tx_valid_q;
    assign tx_last  = tx_last_q;
    assign busy     = (state_q != ST_IDLE);
    assign seq_err  = seq_err_q;
    assign mode_err = mode_err_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_simon_out_serializer.sv
// Bench for simon_out_serializer: directed packets plus random traffic against a packet-level model.
module tb_simon_out_serializer;

    localparam int N     = 16;
    localparam int BYTES = 2 + N / 2;

    logic               clk = 1'b0;
    logic               nR = 1'b0;
    logic               doneOUT = 1'b0;
    logic               tx_ready = 1'b0;
    logic [BYTES*8-1:0] pkt_in = '0;
    logic               readOUT, tx_valid, tx_last, busy, seq_err, mode_err;
    logic [7:0]         tx_data, drop_cnt;

    int total = 0;
    int bad   = 0;

    int m_exp  = 0;
    int m_drop = 0;
    bit m_seq  = 1'b0;
    bit m_mode = 1'b0;

    logic [BYTES*8-1:0] p0;

    always #5 clk = ~clk;

    simon_out_serializer #(.N(N), .MODE(0)) dut (
        .clk      (clk),
        .nR       (nR),
        .doneOUT  (doneOUT),
        .pkt_in   (pkt_in),
        .readOUT  (readOUT),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_last  (tx_last),
        .busy     (busy),
        .seq_err  (seq_err),
        .mode_err (mode_err),
        .drop_cnt (drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_flags(input string tag);
        chk({tag, "_valid"}, tx_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_seq"}, seq_err, m_seq);
        chk({tag, "_mode"}, mode_err, m_mode);
        chk({tag, "_drop"}, drop_cnt, m_drop[7:0]);
    endtask

    task automatic model_reset();
        m_exp  = 0;
        m_drop = 0;
        m_seq  = 1'b0;
        m_mode = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rd"}, readOUT, 1'b0);
        chk({tag, "_data"}, tx_data, 8'h00);
        chk({tag, "_last"}, tx_last, 1'b0);
        chk_idle_flags(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        nR = 1'b0;
        doneOUT = 1'b0;
        tx_ready = 1'b0;
        @(negedge clk);
        model_reset();
        chk_reset_state("rst");
        nR = 1'b1;
    endtask

    // Caller is at a negedge. rmode: 0 ready always, 1 toggling, 2 random.
    // abort >= 0 pulses nR after that many bytes have been transferred.
    task automatic run_packet(input logic [BYTES*8-1:0] p, input int rmode,
                              input int hold, input int abort);
        logic [7:0] bq [BYTES];
        logic [7:0] info, cnt, prev_data;
        bit got, prev_stall, rdy;
        int idx, cyc, lat;

        for (int i = 0; i < BYTES; i++) bq[i] = p[(BYTES-1-i)*8 +: 8];
        info = bq[0];
        cnt  = bq[1];

        doneOUT = 1'b1;
        pkt_in  = p;
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            lat++;
            got = readOUT;
        end
        chk("rd_seen", got, 1'b1);
        if (!got) begin
            doneOUT = 1'b0;
            return;
        end
        chk("rd_latency", lat, 1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("rd_once", readOUT, 1'b0);
            chk("ack_busy", busy, 1'b1);
            chk("ack_novalid", tx_valid, 1'b0);
        end
        doneOUT = 1'b0;

        if (!info[4]) begin
            m_drop = (m_drop + 1) % 256;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("drop_novalid", tx_valid, 1'b0);
                chk("drop_rd", readOUT, 1'b0);
            end
            chk_idle_flags("drop");
            return;
        end

        if (cnt != m_exp[7:0]) m_seq = 1'b1;
        m_exp = (cnt + 1) % 256;
        if (info[3:0] != 4'd0) m_mode = 1'b1;

        idx = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_data = 8'h00;
        while (idx < BYTES && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (idx == abort) begin
                nR = 1'b0;
                tx_ready = 1'b0;
                @(negedge clk);
                model_reset();
                chk_reset_state("midrst");
                nR = 1'b1;
                return;
            end
            if (cyc == 1) begin
                chk("rd_pulse", readOUT, 1'b0);
                chk("first_valid", tx_valid, 1'b1);
            end
            if (prev_stall) begin
                chk("stall_valid", tx_valid, 1'b1);
                chk("stall_data", tx_data, prev_data);
            end
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 1);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            tx_ready = rdy;
            if (tx_valid) chk("last", tx_last, (idx == BYTES - 1));
            if (tx_valid && rdy) begin
                chk("byte", tx_data, bq[idx]);
                idx++;
            end
            prev_stall = tx_valid && !rdy;
            prev_data  = tx_data;
        end
        chk("xfers", idx, BYTES);
        if (rmode == 0) chk("cycles", cyc, BYTES);
        @(negedge clk);
        tx_ready = 1'b0;
        chk_idle_flags("done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  r_info, r_cnt;
        logic [63:0] r_data;

        p0 = {8'h10, 8'h00, 64'h0123_4567_89AB_CDEF};

        nR = 1'b0;
        doneOUT = 1'b1;
        pkt_in = '0;
        repeat (2) @(negedge clk);
        chk_reset_state("por");
        nR = 1'b1;
        run_packet('0, 0, 0, -1);

        run_packet(p0, 0, 0, -1);

        do_reset();
        run_packet(p0, 1, 1, -1);

        do_reset();
        run_packet({8'h10, 8'h00, 64'h1111_2222_3333_4444}, 0, 0, -1);
        run_packet({8'h10, 8'h01, 64'h5555_6666_7777_8888}, 0, 2, -1);
        chk("seq_before_gap", seq_err, 1'b0);
        run_packet({8'h10, 8'h03, 64'h9999_AAAA_BBBB_CCCC}, 2, 0, -1);
        chk("seq_gap", seq_err, 1'b1);
        run_packet({8'h10, 8'h04, 64'hDDDD_EEEE_FFFF_0000}, 0, 0, -1);
        chk("seq_sticky", seq_err, 1'b1);

        run_packet({8'h11, 8'h05, 64'h0F1E_2D3C_4B5A_6978}, 0, 0, -1);
        chk("mode_set", mode_err, 1'b1);

        do_reset();
        run_packet(p0, 0, 0, 4);
        run_packet(p0, 0, 0, -1);
        chk("seq_after_rst", seq_err, 1'b0);

        for (int k = 0; k < 30; k++) begin
            r_info = 8'($urandom);
            r_info[4] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) != 0) r_info[3:0] = 4'd0;
            r_cnt = ($urandom_range(0, 5) == 0) ? 8'($urandom) : m_exp[7:0];
            r_data = {$urandom, $urandom};
            run_packet({r_info, r_cnt, r_data}, 2, $urandom_range(0, 2), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
